// File: rtl/if_hazard_ctrl_if.sv
// Signal bundle between the IF-stage hazard controller and the pipeline:
// EX/ID hazard inputs, the fetch handshake, PC/IF-ID controls and event counters.
interface if_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             ex_redirect;
    logic [31:0]      ex_target;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic             imem_ready;
    logic             pcop;
    logic [31:0]      npc_out;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ex_redirect, ex_target, ex_mem_read, ex_rd,
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, imem_ready,
        input  pcop, npc_out, pc_we, ifid_we, ifid_flush, idex_flush,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  ex_redirect, ex_target, ex_mem_read, ex_rd,
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, imem_ready,
        output pcop, npc_out, pc_we, ifid_we, ifid_flush, idex_flush,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/if_hazard_ctrl.sv
// Front-end sequencer for the pipelined RV32 core: PC select/enable, IF/ID write and
// IF/ID, ID/EX flush control for EX redirects, load-use stalls and imem wait states.
module if_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 32
) (
    input  logic            clk,
    input  logic            rst,
    if_hazard_ctrl_if.slave bus
);
    localparam int LW = $clog2(LOAD_STALL_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        REDIR_PEND = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [31:0]      tgt_r;
    logic [31:0]      tgt_nxt_s;
    logic [LW-1:0]    lcnt_r;
    logic [LW-1:0]    lcnt_nxt_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic             hazard_s;
    logic             pcop_s;
    logic [31:0]      npc_s;
    logic             pc_we_s;
    logic             ifid_we_s;
    logic             ifid_flush_s;
    logic             idex_flush_s;

    function automatic logic load_use(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       rs1_used,
        input logic       rs2_used
    );
        return mem_read && (rd != 5'd0) &&
               ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
    endfunction

    // Counters stick at all-ones instead of wrapping so long runs stay monotonic.
    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v,
        input logic             en
    );
        logic [CNT_W-1:0] r;
        if (en && (v != {CNT_W{1'b1}})) begin
            r = v + CNT_W'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    assign hazard_s = load_use(bus.ex_mem_read, bus.ex_rd, bus.id_rs1, bus.id_rs2,
                               bus.id_rs1_used, bus.id_rs2_used);

    // State, pending redirect target and bubble counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
            tgt_r   <= 32'd0;
            lcnt_r  <= {LW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            tgt_r   <= tgt_nxt_s;
            lcnt_r  <= lcnt_nxt_s;
        end
    end

    // Next-state selection; a new redirect overrides every older condition.
    always_comb begin
        state_nxt_s = state_r;
        tgt_nxt_s   = tgt_r;
        lcnt_nxt_s  = lcnt_r;
        if (bus.ex_redirect) begin
            lcnt_nxt_s = {LW{1'b0}};
            if (bus.imem_ready) begin
                state_nxt_s = RUN;
            end else begin
                state_nxt_s = REDIR_PEND;
                tgt_nxt_s   = bus.ex_target;
            end
        end else begin
            case (state_r)
                REDIR_PEND: begin
                    if (bus.imem_ready) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = REDIR_PEND;
                    end
                end
                LOAD_STALL: begin
                    lcnt_nxt_s = lcnt_r - LW'(1);
                    if (lcnt_r == LW'(1)) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = LOAD_STALL;
                    end
                end
                RUN: begin
                    if (hazard_s) begin
                        lcnt_nxt_s  = LW'(LOAD_STALL_CYCLES - 1);
                        state_nxt_s = (LOAD_STALL_CYCLES > 1) ? LOAD_STALL : RUN;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                default: begin
                    state_nxt_s = RUN;
                end
            endcase
        end
    end

    // Pipeline control outputs, decoded from state and the current-cycle inputs.
    always_comb begin
        pcop_s       = 1'b0;
        npc_s        = tgt_r;
        pc_we_s      = 1'b0;
        ifid_we_s    = 1'b0;
        ifid_flush_s = 1'b0;
        idex_flush_s = 1'b0;
        if (rst) begin
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
        end else if (bus.ex_redirect) begin
            pcop_s       = 1'b1;
            npc_s        = bus.ex_target;
            pc_we_s      = bus.imem_ready;
            ifid_we_s    = 1'b1;
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
        end else begin
            case (state_r)
                REDIR_PEND: begin
                    pcop_s       = 1'b1;
                    pc_we_s      = bus.imem_ready;
                    ifid_we_s    = 1'b1;
                    ifid_flush_s = 1'b1;
                end
                LOAD_STALL: begin
                    idex_flush_s = 1'b1;
                end
                RUN: begin
                    // A load-use hazard holds the ID instruction even during an imem wait.
                    if (hazard_s) begin
                        idex_flush_s = 1'b1;
                    end else if (!bus.imem_ready) begin
                        ifid_we_s    = 1'b1;
                        ifid_flush_s = 1'b1;
                    end else begin
                        pc_we_s   = 1'b1;
                        ifid_we_s = 1'b1;
                    end
                end
                default: begin
                    idex_flush_s = 1'b1;
                    ifid_flush_s = 1'b1;
                end
            endcase
        end
    end

    // Saturating stall (pc_we low) and accepted-redirect counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_r <= sat_inc(stall_cnt_r, !pc_we_s);
            flush_cnt_r <= sat_inc(flush_cnt_r, bus.ex_redirect);
        end
    end

    assign bus.pcop       = pcop_s;
    assign bus.npc_out    = npc_s;
    assign bus.pc_we      = pc_we_s;
    assign bus.ifid_we    = ifid_we_s;
    assign bus.ifid_flush = ifid_flush_s;
    assign bus.idex_flush = idex_flush_s;
    assign bus.stall_cnt  = stall_cnt_r;
    assign bus.flush_cnt  = flush_cnt_r;
endmodule

// File: tb/tb_if_hazard_ctrl.sv
// Bench for if_hazard_ctrl: two instances (1-bubble/32-bit counters and 2-bubble/4-bit
// counters) driven by directed vectors, corner sequences and random stimulus.
module tb_if_hazard_ctrl;
    typedef struct {
        bit          rst;
        bit          redir;
        logic [31:0] tgt;
        bit          mr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        bit          u1;
        bit          u2;
        bit          rdy;
    } stim_t;

    typedef struct {
        bit          pcop;
        logic [31:0] npc;
        bit          pc_we;
        bit          ifid_we;
        bit          if_fl;
        bit          id_fl;
        bit          ck_pcop;
        bit          ck_npc;
        bit          ck_ifwe;
    } exp_t;

    typedef struct {
        stim_t       s;
        exp_t        e;
        logic [31:0] sc;
        logic [31:0] fc;
    } vec_t;

    // Reference model: pending redirect flag, remaining bubbles, saved target, event counts.
    typedef struct {
        bit          pend;
        int          rem;
        logic [31:0] tgt;
        longint      stall;
        longint      flush;
    } mdl_t;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;
    mdl_t ma;
    mdl_t mb;
    vec_t vecs[17];

    always #5 clk = ~clk;

    if_hazard_ctrl_if #(.CNT_W(32)) if_a ();
    if_hazard_ctrl_if #(.CNT_W(4))  if_b ();

    if_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    if_hazard_ctrl #(.LOAD_STALL_CYCLES(2), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(if_b));

    function automatic stim_t st(input bit r, input bit rdr, input logic [31:0] tg, input bit mr,
                                 input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b,
                                 input bit ua, input bit ub, input bit rdy);
        stim_t s;
        s.rst = r; s.redir = rdr; s.tgt = tg; s.mr = mr; s.rd = rd;
        s.rs1 = a; s.rs2 = b; s.u1 = ua; s.u2 = ub; s.rdy = rdy;
        return s;
    endfunction

    function automatic exp_t ex(input bit pcop, input logic [31:0] npc, input bit pc_we, input bit ifid_we,
                                input bit if_fl, input bit id_fl, input bit cp, input bit cn, input bit ci);
        exp_t e;
        e.pcop = pcop; e.npc = npc; e.pc_we = pc_we; e.ifid_we = ifid_we; e.if_fl = if_fl;
        e.id_fl = id_fl; e.ck_pcop = cp; e.ck_npc = cn; e.ck_ifwe = ci;
        return e;
    endfunction

    function automatic bit hz(input stim_t s);
        return s.mr && (s.rd != 5'd0) && ((s.u1 && (s.rs1 == s.rd)) || (s.u2 && (s.rs2 == s.rd)));
    endfunction

    function automatic exp_t mdl_eval(input stim_t s, input mdl_t m);
        exp_t e;
        e = ex(1'b0, m.tgt, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        if (s.rst) begin
            e.if_fl = 1'b1; e.id_fl = 1'b1; e.ck_npc = 1'b0;
        end else if (s.redir) begin
            e.if_fl = 1'b1; e.id_fl = 1'b1; e.ck_ifwe = 1'b0;
            if (s.rdy) begin
                e.pcop = 1'b1; e.npc = s.tgt; e.pc_we = 1'b1;
            end else begin
                e.ck_pcop = 1'b0; e.ck_npc = 1'b0;
            end
        end else if (m.pend) begin
            e.pcop = 1'b1; e.if_fl = 1'b1; e.pc_we = s.rdy; e.ck_ifwe = 1'b0;
        end else if (m.rem > 0 || hz(s)) begin
            e.id_fl = 1'b1;
        end else if (!s.rdy) begin
            e.ifid_we = 1'b1; e.if_fl = 1'b1; e.ck_pcop = 1'b0;
        end else begin
            e.pc_we = 1'b1; e.ifid_we = 1'b1;
        end
        return e;
    endfunction

    function automatic mdl_t mdl_next(input int n, input longint cmax, input stim_t s,
                                      input mdl_t m, input exp_t e);
        mdl_t r;
        r = m;
        if (s.rst) begin
            r.pend = 1'b0; r.rem = 0; r.tgt = 32'd0; r.stall = 0; r.flush = 0;
            return r;
        end
        if (!e.pc_we && r.stall < cmax) r.stall++;
        if (s.redir && r.flush < cmax) r.flush++;
        if (s.redir) begin
            r.rem  = 0;
            r.pend = !s.rdy;
            if (!s.rdy) r.tgt = s.tgt;
        end else if (m.pend) begin
            r.pend = !s.rdy;
        end else if (m.rem > 0) begin
            r.rem--;
        end else if (hz(s)) begin
            r.rem = n - 1;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cmp(input string tag, input exp_t e, input mdl_t m,
                       input logic pcop, input logic [31:0] npc, input logic pc_we, input logic ifid_we,
                       input logic if_fl, input logic id_fl, input logic [31:0] sc, input logic [31:0] fc);
        if (e.ck_pcop) check({tag, ".pcop"}, {31'd0, pcop}, {31'd0, e.pcop});
        if (e.ck_npc)  check({tag, ".npc_out"}, npc, e.npc);
        check({tag, ".pc_we"}, {31'd0, pc_we}, {31'd0, e.pc_we});
        if (e.ck_ifwe) check({tag, ".ifid_we"}, {31'd0, ifid_we}, {31'd0, e.ifid_we});
        check({tag, ".ifid_flush"}, {31'd0, if_fl}, {31'd0, e.if_fl});
        check({tag, ".idex_flush"}, {31'd0, id_fl}, {31'd0, e.id_fl});
        check({tag, ".stall_cnt"}, sc, m.stall[31:0]);
        check({tag, ".flush_cnt"}, fc, m.flush[31:0]);
    endtask

    task automatic drive(input stim_t s);
        rst = s.rst;
        if_a.ex_redirect = s.redir; if_a.ex_target = s.tgt; if_a.ex_mem_read = s.mr;
        if_a.ex_rd = s.rd; if_a.id_rs1 = s.rs1; if_a.id_rs2 = s.rs2;
        if_a.id_rs1_used = s.u1; if_a.id_rs2_used = s.u2; if_a.imem_ready = s.rdy;
        if_b.ex_redirect = s.redir; if_b.ex_target = s.tgt; if_b.ex_mem_read = s.mr;
        if_b.ex_rd = s.rd; if_b.id_rs1 = s.rs1; if_b.id_rs2 = s.rs2;
        if_b.id_rs1_used = s.u1; if_b.id_rs2_used = s.u2; if_b.imem_ready = s.rdy;
    endtask

    // One clock: apply inputs after the falling edge, compare both DUTs to the model, advance it.
    task automatic run_cycle(input stim_t s, input string tag);
        exp_t ea;
        exp_t eb;
        @(negedge clk);
        drive(s);
        #1;
        ea = mdl_eval(s, ma);
        eb = mdl_eval(s, mb);
        cmp({tag, ".a"}, ea, ma, if_a.pcop, if_a.npc_out, if_a.pc_we, if_a.ifid_we,
            if_a.ifid_flush, if_a.idex_flush, if_a.stall_cnt, if_a.flush_cnt);
        cmp({tag, ".b"}, eb, mb, if_b.pcop, if_b.npc_out, if_b.pc_we, if_b.ifid_we,
            if_b.ifid_flush, if_b.idex_flush, {28'd0, if_b.stall_cnt}, {28'd0, if_b.flush_cnt});
        ma = mdl_next(1, 64'h0000_0000_FFFF_FFFF, s, ma, ea);
        mb = mdl_next(2, 64'h0000_0000_0000_000F, s, mb, eb);
    endtask

    initial begin
        stim_t idle;
        stim_t rs;
        stim_t s;
        exp_t  nrm;
        exp_t  hzd;
        exp_t  rsx;

        idle = st(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        rs   = st(1'b1, 1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        nrm  = ex(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        hzd  = ex(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        rsx  = ex(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

        ma = '{pend: 1'b0, rem: 0, tgt: 32'd0, stall: 0, flush: 0};
        mb = ma;
        drive(rs);

        // Directed vectors, expectations for the 1-bubble / 32-bit instance.
        vecs[0]  = '{rs, rsx, 32'd0, 32'd0};
        vecs[1]  = '{rs, rsx, 32'd0, 32'd0};
        vecs[2]  = '{idle, nrm, 32'd0, 32'd0};
        vecs[3]  = '{st(1'b0, 1'b0, 32'd0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1), hzd, 32'd0, 32'd0};
        vecs[4]  = '{idle, nrm, 32'd1, 32'd0};
        vecs[5]  = '{st(1'b0, 1'b0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1), nrm, 32'd1, 32'd0};
        vecs[6]  = '{st(1'b0, 1'b0, 32'd0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1, 1'b1), hzd, 32'd1, 32'd0};
        vecs[7]  = '{st(1'b0, 1'b0, 32'd0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b1), nrm, 32'd2, 32'd0};
        vecs[8]  = '{st(1'b0, 1'b1, 32'h100, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1),
                     ex(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0), 32'd2, 32'd0};
        vecs[9]  = '{idle, nrm, 32'd2, 32'd1};
        vecs[10] = '{st(1'b0, 1'b1, 32'h200, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0),
                     ex(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 32'd2, 32'd1};
        vecs[11] = '{st(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0),
                     ex(1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0), 32'd3, 32'd2};
        vecs[12] = '{st(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0),
                     ex(1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0), 32'd4, 32'd2};
        vecs[13] = '{idle, ex(1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0), 32'd5, 32'd2};
        vecs[14] = '{idle, ex(1'b0, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1), 32'd5, 32'd2};
        vecs[15] = '{st(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0),
                     ex(1'b0, 32'h200, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1), 32'd5, 32'd2};
        vecs[16] = '{idle, ex(1'b0, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1), 32'd6, 32'd2};

        for (int i = 0; i < 17; i++) begin
            string tg;
            tg = $sformatf("vec%0d", i);
            run_cycle(vecs[i].s, tg);
            if (vecs[i].e.ck_pcop) check({tg, ".tbl.pcop"}, {31'd0, if_a.pcop}, {31'd0, vecs[i].e.pcop});
            if (vecs[i].e.ck_npc)  check({tg, ".tbl.npc_out"}, if_a.npc_out, vecs[i].e.npc);
            check({tg, ".tbl.pc_we"}, {31'd0, if_a.pc_we}, {31'd0, vecs[i].e.pc_we});
            if (vecs[i].e.ck_ifwe) check({tg, ".tbl.ifid_we"}, {31'd0, if_a.ifid_we}, {31'd0, vecs[i].e.ifid_we});
            check({tg, ".tbl.ifid_flush"}, {31'd0, if_a.ifid_flush}, {31'd0, vecs[i].e.if_fl});
            check({tg, ".tbl.idex_flush"}, {31'd0, if_a.idex_flush}, {31'd0, vecs[i].e.id_fl});
            check({tg, ".tbl.stall_cnt"}, if_a.stall_cnt, vecs[i].sc);
            check({tg, ".tbl.flush_cnt"}, if_a.flush_cnt, vecs[i].fc);
        end

        // Redirect arriving mid load-stall on the 2-bubble instance wins immediately.
        run_cycle(rs, "ls_rst");
        s = st(1'b0, 1'b0, 32'd0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
        run_cycle(s, "ls_hz");
        check("ls_hz.b.pc_we", {31'd0, if_b.pc_we}, 32'd0);
        s.redir = 1'b1;
        s.tgt   = 32'h300;
        run_cycle(s, "ls_redir");
        check("ls_redir.b.pc_we", {31'd0, if_b.pc_we}, 32'd1);
        check("ls_redir.b.pcop", {31'd0, if_b.pcop}, 32'd1);
        check("ls_redir.b.npc_out", if_b.npc_out, 32'h300);
        run_cycle(idle, "ls_after");
        check("ls_after.b.pc_we", {31'd0, if_b.pc_we}, 32'd1);
        check("ls_after.b.ifid_we", {31'd0, if_b.ifid_we}, 32'd1);

        // 20 imem-wait cycles: 4-bit stall counter pins at 4'hF, 32-bit one reaches 20.
        run_cycle(rs, "sat_rst");
        s = st(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) run_cycle(s, "sat_wait");
        run_cycle(idle, "sat_end");
        check("sat.b.stall_cnt", {28'd0, if_b.stall_cnt}, 32'h0000_000F);
        check("sat.a.stall_cnt", if_a.stall_cnt, 32'd20);

        // Random traffic against the reference model.
        run_cycle(rs, "rnd_rst");
        for (int i = 0; i < 400; i++) begin
            s.rst   = ($urandom_range(0, 49) == 0);
            s.redir = ($urandom_range(0, 7) == 0);
            s.tgt   = $urandom & 32'hFFFF_FFFC;
            s.mr    = ($urandom_range(0, 2) == 0);
            s.rd    = 5'($urandom_range(0, 3));
            s.rs1   = 5'($urandom_range(0, 3));
            s.rs2   = 5'($urandom_range(0, 3));
            s.u1    = 1'($urandom_range(0, 1));
            s.u2    = 1'($urandom_range(0, 1));
            s.rdy   = ($urandom_range(0, 3) != 0);
            run_cycle(s, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
